// File: rtl/exmem_stage_ctrl_if.sv
// EX/MEM controller bus: pipeline-register fields, data-memory handshake and control outputs.
// master = the stage controller, slave = pipeline/memory side.
interface exmem_stage_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             valid_EXMem;
  logic             MemRW_EXMem;
  logic [1:0]       MemtoReg_EXMem;
  logic             Branch_EXMem;
  logic             BranchN_EXMem;
  logic             Jump_EXMem;
  logic             zero_EXMem;
  logic [31:0]      PC_imm_EXMem;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             en_EXMem;
  logic             en_upstream;
  logic             flush_IFID;
  logic             flush_IDEX;
  logic             pc_src;
  logic [31:0]      pc_target;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    input  valid_EXMem, MemRW_EXMem, MemtoReg_EXMem, Branch_EXMem, BranchN_EXMem,
           Jump_EXMem, zero_EXMem, PC_imm_EXMem, mem_ack,
    output mem_req, mem_we, en_EXMem, en_upstream, flush_IFID, flush_IDEX,
           pc_src, pc_target, mem_err, stall_cnt, redirect_cnt
  );

  modport slave (
    output valid_EXMem, MemRW_EXMem, MemtoReg_EXMem, Branch_EXMem, BranchN_EXMem,
           Jump_EXMem, zero_EXMem, PC_imm_EXMem, mem_ack,
    input  mem_req, mem_we, en_EXMem, en_upstream, flush_IFID, flush_IDEX,
           pc_src, pc_target, mem_err, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/exmem_stage_ctrl.sv
// EX/MEM stage controller: data-memory req/ack sequencing with stall and timeout watchdog,
// branch/jump redirect with flushes, and saturating stall/redirect counters.
module exmem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk_EXMem,
  input logic               rst_EXMem,
  exmem_stage_ctrl_if.master bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  logic mem_op_c, taken_c, stall_c, req_c, redirect_c;

  assign mem_op_c = bus.valid_EXMem & (bus.MemRW_EXMem | (bus.MemtoReg_EXMem == 2'b01));
  assign taken_c  = bus.valid_EXMem & (bus.Jump_EXMem
                                     | (bus.Branch_EXMem & bus.zero_EXMem)
                                     | (bus.BranchN_EXMem & ~bus.zero_EXMem));

  // Next state; a timed-out access is dropped without stalling so the pipeline advances.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    mem_err_d = mem_err_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_c = mem_op_c;
        if (mem_op_c && !bus.mem_ack) begin
          stall_c = 1'b1;
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (bus.mem_ack) begin
          state_d = S_IDLE;
          wd_d    = '0;
        end else if (wd_q == TO_W'(TIMEOUT)) begin
          mem_err_d = 1'b1;
          state_d   = S_IDLE;
          wd_d      = '0;
        end else begin
          stall_c = 1'b1;
          wd_d    = wd_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A stall outranks a redirect, so an illegal branch+memory encoding redirects on release.
  assign redirect_c = taken_c & ~stall_c;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_c && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_c && (redirect_cnt_q != '1))
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_EXMem or posedge rst_EXMem) begin
    if (rst_EXMem) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      mem_err_q      <= 1'b0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      mem_err_q      <= mem_err_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.mem_req      = req_c;
  assign bus.mem_we       = bus.MemRW_EXMem & req_c;
  assign bus.en_EXMem     = ~stall_c;
  assign bus.en_upstream  = ~stall_c;
  assign bus.flush_IFID   = redirect_c;
  assign bus.flush_IDEX   = redirect_c;
  assign bus.pc_src       = redirect_c;
  assign bus.pc_target    = bus.PC_imm_EXMem;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_exmem_stage_ctrl.sv
// Directed self-checking bench for exmem_stage_ctrl; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_exmem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, memrw = 1'b0, branch = 1'b0, branchn = 1'b0, jump = 1'b0;
  logic        zero = 1'b0, ack = 1'b0;
  logic [1:0]  memtoreg = 2'b00;
  logic [31:0] pc_imm = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  exmem_stage_ctrl_if #(.CNT_W(16)) bus ();
  exmem_stage_ctrl_if #(.CNT_W(4))  bus_s ();

  assign bus.valid_EXMem    = valid;   assign bus_s.valid_EXMem    = valid;
  assign bus.MemRW_EXMem    = memrw;   assign bus_s.MemRW_EXMem    = memrw;
  assign bus.MemtoReg_EXMem = memtoreg; assign bus_s.MemtoReg_EXMem = memtoreg;
  assign bus.Branch_EXMem   = branch;  assign bus_s.Branch_EXMem   = branch;
  assign bus.BranchN_EXMem  = branchn; assign bus_s.BranchN_EXMem  = branchn;
  assign bus.Jump_EXMem     = jump;    assign bus_s.Jump_EXMem     = jump;
  assign bus.zero_EXMem     = zero;    assign bus_s.zero_EXMem     = zero;
  assign bus.PC_imm_EXMem   = pc_imm;  assign bus_s.PC_imm_EXMem   = pc_imm;
  assign bus.mem_ack        = ack;     assign bus_s.mem_ack        = ack;

  exmem_stage_ctrl #(.TIMEOUT(15), .TO_W(4), .CNT_W(16)) dut (
    .clk_EXMem(clk), .rst_EXMem(rst), .bus(bus)
  );

  exmem_stage_ctrl #(.TIMEOUT(15), .TO_W(4), .CNT_W(4)) dut_sat (
    .clk_EXMem(clk), .rst_EXMem(rst), .bus(bus_s)
  );

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; memrw = 0; memtoreg = 2'b00; branch = 0; branchn = 0; jump = 0;
    zero = 0; ack = 0; pc_imm = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
    n_checks++; if ({bus.en_EXMem, bus.en_upstream} !== 2'b11) begin n_fail++; $display("FAIL reset_en got %b exp 11", {bus.en_EXMem, bus.en_upstream}); end
    n_checks++; if ({bus.pc_src, bus.flush_IFID, bus.flush_IDEX} !== 3'b000) begin n_fail++; $display("FAIL reset_redirect got %b exp 000", {bus.pc_src, bus.flush_IFID, bus.flush_IDEX}); end
    n_checks++; if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got %b exp 0", bus.mem_err); end
    n_checks++; if ({bus.stall_cnt, bus.redirect_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {bus.stall_cnt, bus.redirect_cnt}); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero_wait_load();
    valid = 1; memtoreg = 2'b01; ack = 1;
    #1;
    n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL zw_load_req_we got %b exp 10", {bus.mem_req, bus.mem_we}); end
    n_checks++; if ({bus.en_EXMem, bus.en_upstream} !== 2'b11) begin n_fail++; $display("FAIL zw_load_en got %b exp 11", {bus.en_EXMem, bus.en_upstream}); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL zw_load_stall_cnt got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_store_3cycle();
    step();
    valid = 1; memrw = 1; ack = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_req_we c%0d got %b exp 11", c, {bus.mem_req, bus.mem_we}); end
      n_checks++; if ({bus.en_EXMem, bus.en_upstream} !== 2'b00) begin n_fail++; $display("FAIL store_en_stall c%0d got %b exp 00", c, {bus.en_EXMem, bus.en_upstream}); end
      step();
    end
    ack = 1;
    #1;
    n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_ack_req_we got %b exp 11", {bus.mem_req, bus.mem_we}); end
    n_checks++; if ({bus.en_EXMem, bus.en_upstream} !== 2'b11) begin n_fail++; $display("FAIL store_ack_en got %b exp 11", {bus.en_EXMem, bus.en_upstream}); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL store_stall_cnt got %0d exp 2", bus.stall_cnt); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL store_back_to_idle req got %b exp 0", bus.mem_req); end
  endtask

  task automatic test_branches();
    step();
    valid = 1; branch = 1; zero = 1; pc_imm = 32'h0000_0040;
    #1;
    n_checks++; if ({bus.pc_src, bus.flush_IFID, bus.flush_IDEX} !== 3'b111) begin n_fail++; $display("FAIL beq_taken got %b exp 111", {bus.pc_src, bus.flush_IFID, bus.flush_IDEX}); end
    n_checks++; if (bus.pc_target !== 32'h40) begin n_fail++; $display("FAIL beq_target got %h exp 00000040", bus.pc_target); end
    step();
    idle_inputs();
    #1;
    n_checks++; if ({bus.pc_src, bus.flush_IFID} !== 2'b00) begin n_fail++; $display("FAIL beq_one_cycle got %b exp 00", {bus.pc_src, bus.flush_IFID}); end
    n_checks++; if (bus.redirect_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_redirect_cnt got %0d exp 1", bus.redirect_cnt); end
    valid = 1; branchn = 1; zero = 1;
    #1;
    n_checks++; if (bus.pc_src !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken got %b exp 0", bus.pc_src); end
    step();
    branchn = 0; jump = 1; zero = 0; pc_imm = 32'h0000_1234;
    #1;
    n_checks++; if ({bus.pc_src, bus.pc_target} !== {1'b1, 32'h0000_1234}) begin n_fail++; $display("FAIL jmp_z0 got %b/%h exp 1/00001234", bus.pc_src, bus.pc_target); end
    step();
    zero = 1;
    #1;
    n_checks++; if (bus.pc_src !== 1'b1) begin n_fail++; $display("FAIL jmp_z1 got %b exp 1", bus.pc_src); end
    step();
    jump = 0; branch = 1; branchn = 1; zero = 0;
    #1;
    n_checks++; if (bus.pc_src !== 1'b1) begin n_fail++; $display("FAIL beq_bne_both got %b exp 1", bus.pc_src); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.redirect_cnt !== 16'd4) begin n_fail++; $display("FAIL branches_redirect_cnt got %0d exp 4", bus.redirect_cnt); end
  endtask

  task automatic test_timeout();
    int stalled;
    valid = 1; memtoreg = 2'b01; ack = 0;
    stalled = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.en_EXMem === 1'b0) stalled++;
      step();
    end
    n_checks++; if (stalled !== 16) begin n_fail++; $display("FAIL timeout_stall_len got %0d exp 16", stalled); end
    #1;
    n_checks++; if ({bus.mem_req, bus.en_EXMem, bus.mem_err} !== 3'b110) begin n_fail++; $display("FAIL timeout_release got %b exp 110", {bus.mem_req, bus.en_EXMem, bus.mem_err}); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL timeout_mem_err got %b exp 1", bus.mem_err); end
    n_checks++; if (bus.stall_cnt !== 16'd18) begin n_fail++; $display("FAIL timeout_stall_cnt got %0d exp 18", bus.stall_cnt); end
    // Late ack with no memory op must be ignored.
    ack = 1;
    #1;
    n_checks++; if ({bus.mem_req, bus.en_EXMem} !== 2'b01) begin n_fail++; $display("FAIL late_ack got %b exp 01", {bus.mem_req, bus.en_EXMem}); end
    step();
    valid = 1; memtoreg = 2'b01; ack = 1;
    #1;
    n_checks++; if ({bus.mem_req, bus.en_EXMem} !== 2'b11) begin n_fail++; $display("FAIL post_timeout_load got %b exp 11", {bus.mem_req, bus.en_EXMem}); end
    step();
    idle_inputs();
    #1;
    n_checks++; if ({bus.mem_err, bus.stall_cnt} !== {1'b1, 16'd18}) begin n_fail++; $display("FAIL mem_err_sticky got %b/%0d exp 1/18", bus.mem_err, bus.stall_cnt); end
  endtask

  task automatic test_illegal_branch_mem();
    valid = 1; memtoreg = 2'b01; branch = 1; zero = 1; pc_imm = 32'h0000_0080; ack = 0;
    #1;
    n_checks++; if ({bus.pc_src, bus.en_EXMem} !== 2'b00) begin n_fail++; $display("FAIL illegal_stall_first got %b exp 00", {bus.pc_src, bus.en_EXMem}); end
    step();
    ack = 1;
    #1;
    n_checks++; if ({bus.pc_src, bus.en_EXMem} !== 2'b11) begin n_fail++; $display("FAIL illegal_redirect_on_release got %b exp 11", {bus.pc_src, bus.en_EXMem}); end
    step();
    idle_inputs();
    #1;
    n_checks++; if ({bus.stall_cnt, bus.redirect_cnt} !== {16'd19, 16'd5}) begin n_fail++; $display("FAIL illegal_counters got %0d/%0d exp 19/5", bus.stall_cnt, bus.redirect_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    valid = 1; memtoreg = 2'b01; ack = 0;
    step();
    #1;
    n_checks++; if (bus.en_EXMem !== 1'b0) begin n_fail++; $display("FAIL mid_wait_stalled got %b exp 0", bus.en_EXMem); end
    rst = 1; valid = 0;
    #1;
    n_checks++; if ({bus.mem_req, bus.en_EXMem, bus.en_upstream} !== 3'b011) begin n_fail++; $display("FAIL mid_wait_reset_outputs got %b exp 011", {bus.mem_req, bus.en_EXMem, bus.en_upstream}); end
    n_checks++; if ({bus.mem_err, bus.stall_cnt, bus.redirect_cnt} !== 33'h0) begin n_fail++; $display("FAIL mid_wait_reset_state got %b/%0d/%0d exp 0/0/0", bus.mem_err, bus.stall_cnt, bus.redirect_cnt); end
    step();
    idle_inputs();
    rst = 0;
    step();
    #1;
    n_checks++; if ({bus.mem_req, bus.stall_cnt} !== 17'h0) begin n_fail++; $display("FAIL after_reset_idle got %b/%0d exp 0/0", bus.mem_req, bus.stall_cnt); end
  endtask

  task automatic test_saturation();
    valid = 1; memtoreg = 2'b01; ack = 0;
    for (int c = 0; c < 20; c++) step();
    #1;
    n_checks++; if (bus_s.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt got %0d exp 15", bus_s.stall_cnt); end
    n_checks++; if (bus.stall_cnt !== 16'd19) begin n_fail++; $display("FAIL wide_stall_cnt got %0d exp 19", bus.stall_cnt); end
    for (int c = 0; c < 10; c++) step();
    #1;
    n_checks++; if (bus_s.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_no_wrap got %0d exp 15", bus_s.stall_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_3cycle();
    test_branches();
    test_timeout();
    test_illegal_branch_mem();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
